// File: rtl/bus_cycle_sequencer.sv
// rtl/bus_cycle_sequencer.sv - control-bus field sequencer for fetch, read and write cycles
module bus_cycle_sequencer #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int ID_WIDTH    = 5,
    parameter int AMID_WIDTH  = 2,
    parameter int IR_BYTES    = 2,
    parameter int LEN_WIDTH   = 3,
    parameter int MEM_ID      = 4,
    parameter int IR_SID_BASE = 0,
    parameter int PC_AMID     = 0,
    parameter int HOST_AMID   = 1,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [DATA_WIDTH-1:0] data_bus_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_oe,
    output logic [ID_WIDTH-1:0]   mid,
    output logic [ID_WIDTH-1:0]   sid,
    output logic [AMID_WIDTH-1:0] amid,
    output logic                  mid_en,
    output logic                  sid_en,
    output logic                  pc_inr,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);
    localparam int KW = (IR_BYTES > 1) ? $clog2(IR_BYTES) : 1;

    typedef enum logic [2:0] {IDLE, F_SETUP, F_XFER, R_ADDR, R_WAIT, R_CAPT, W_XFER} state_t;

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q, k_d, last_q, last_d;
    logic [3:0]            wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [31:0]           len_req;

    logic                  cmd_ready_q, cmd_ready_d;
    logic [ADDR_WIDTH-1:0] addr_out_q, addr_out_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_oe_q, data_oe_d;
    logic [ID_WIDTH-1:0]   mid_q, mid_d, sid_q, sid_d;
    logic [AMID_WIDTH-1:0] amid_q, amid_d;
    logic                  mid_en_q, mid_en_d, sid_en_q, sid_en_d, pc_inr_q, pc_inr_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        last_d      = last_q;
        wcnt_d      = wcnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = rsp_data_q;
        len_req     = 32'(cmd_len);
        if (len_req == 32'd0 || len_req > 32'(IR_BYTES)) begin
            len_req = 32'(IR_BYTES);
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    k_d     = '0;
                    wcnt_d  = '0;
                    last_d  = KW'(len_req - 32'd1);
                    case (cmd_op)
                        2'b00:   state_d = F_SETUP;
                        2'b01:   state_d = R_ADDR;
                        2'b10:   state_d = W_XFER;
                        default: begin
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                        end
                    endcase
                end
            end
            F_SETUP: state_d = F_XFER;
            F_XFER: begin
                if (k_q == last_q) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = F_SETUP;
                    k_d     = k_q + 1'b1;
                end
            end
            R_ADDR: state_d = (WAIT_STATES == 0) ? R_CAPT : R_WAIT;
            R_WAIT: begin
                if (wcnt_q == 4'(WAIT_STATES - 1)) begin
                    state_d = R_CAPT;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            R_CAPT: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_data_d  = data_bus_in;
            end
            W_XFER: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Bus fields are decoded from the next state so they register in step with it.
        cmd_ready_d = (state_d == IDLE);
        addr_out_d  = '0;
        data_out_d  = '0;
        data_oe_d   = 1'b0;
        mid_d       = '0;
        sid_d       = '0;
        amid_d      = '0;
        mid_en_d    = 1'b0;
        sid_en_d    = 1'b0;
        pc_inr_d    = 1'b0;
        case (state_d)
            F_SETUP, F_XFER: begin
                amid_d   = AMID_WIDTH'(PC_AMID);
                mid_d    = ID_WIDTH'(MEM_ID);
                mid_en_d = 1'b1;
                if (state_d == F_XFER) begin
                    sid_d    = ID_WIDTH'(IR_SID_BASE) + ID_WIDTH'(k_d);
                    sid_en_d = 1'b1;
                    pc_inr_d = 1'b1;
                end
            end
            R_ADDR, R_WAIT, R_CAPT: begin
                amid_d     = AMID_WIDTH'(HOST_AMID);
                addr_out_d = addr_d;
                mid_d      = ID_WIDTH'(MEM_ID);
                mid_en_d   = 1'b1;
            end
            W_XFER: begin
                amid_d     = AMID_WIDTH'(HOST_AMID);
                addr_out_d = addr_d;
                data_out_d = wdata_d;
                data_oe_d  = 1'b1;
                sid_d      = ID_WIDTH'(MEM_ID);
                sid_en_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            last_q      <= '0;
            wcnt_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cmd_ready_q <= 1'b1;
            addr_out_q  <= '0;
            data_out_q  <= '0;
            data_oe_q   <= 1'b0;
            mid_q       <= '0;
            sid_q       <= '0;
            amid_q      <= '0;
            mid_en_q    <= 1'b0;
            sid_en_q    <= 1'b0;
            pc_inr_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            last_q      <= last_d;
            wcnt_q      <= wcnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cmd_ready_q <= cmd_ready_d;
            addr_out_q  <= addr_out_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
            mid_q       <= mid_d;
            sid_q       <= sid_d;
            amid_q      <= amid_d;
            mid_en_q    <= mid_en_d;
            sid_en_q    <= sid_en_d;
            pc_inr_q    <= pc_inr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = ~cmd_ready_q;
    assign addr_out  = addr_out_q;
    assign data_out  = data_out_q;
    assign data_oe   = data_oe_q;
    assign mid       = mid_q;
    assign sid       = sid_q;
    assign amid      = amid_q;
    assign mid_en    = mid_en_q;
    assign sid_en    = sid_en_q;
    assign pc_inr    = pc_inr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
endmodule
